// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// States, instruction classes, datapath select codes, opcodes and functs.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMADR,
        S_MEMRD,
        S_MEMWR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_SHIFT,
        C_IMM,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JUMP,
        C_JLINK,
        C_ILLEGAL
    } iclass_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JMP = 2'd2;
    localparam logic [1:0] NPC_RS  = 2'd3;

    localparam logic [1:0] GPR_RD = 2'd0;
    localparam logic [1:0] GPR_RT = 2'd1;
    localparam logic [1:0] GPR_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] A_PC    = 2'd0;
    localparam logic [1:0] A_RS    = 2'd1;
    localparam logic [1:0] A_SHAMT = 2'd2;

    localparam logic [1:0] B_RT    = 2'd0;
    localparam logic [1:0] B_FOUR  = 2'd1;
    localparam logic [1:0] B_IMM   = 2'd2;
    localparam logic [1:0] B_IMMSH = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier for the multi-cycle controller.
// Maps Op/Funct to an instruction class plus the EXEC ALU op and extend mode.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic [3:0] alu_op,
    output logic       ext_op
);

    always_comb begin
        cls    = C_ILLEGAL;
        alu_op = ALU_NOP;
        ext_op = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls = C_RTYPE;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLLV:         alu_op = ALU_SLL;
                    FN_SRLV:         alu_op = ALU_SRL;
                    FN_SLL: begin
                        cls    = C_SHIFT;
                        alu_op = ALU_SLL;
                    end
                    FN_SRL: begin
                        cls    = C_SHIFT;
                        alu_op = ALU_SRL;
                    end
                    FN_JR:           cls = C_JUMP;
                    FN_JALR:         cls = C_JLINK;
                    default:         cls = C_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                cls    = C_IMM;
                alu_op = ALU_ADD;
                ext_op = 1'b1;
            end
            OP_SLTI: begin
                cls    = C_IMM;
                alu_op = ALU_SLT;
                ext_op = 1'b1;
            end
            OP_ANDI: begin
                cls    = C_IMM;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                cls    = C_IMM;
                alu_op = ALU_OR;
            end
            OP_LUI: begin
                cls    = C_IMM;
                alu_op = ALU_LUI;
            end
            OP_LW: begin
                cls    = C_LOAD;
                alu_op = ALU_ADD;
                ext_op = 1'b1;
            end
            OP_SW: begin
                cls    = C_STORE;
                alu_op = ALU_ADD;
                ext_op = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                cls    = C_BRANCH;
                alu_op = ALU_SUB;
                ext_op = 1'b1;
            end
            OP_J:    cls = C_JUMP;
            OP_JAL:  cls = C_JLINK;
            default: cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/write-back sequencing
// with optional memory wait-states and a retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 4,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_rdy,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               EXTOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    state_t     state;
    state_t     nxt;
    iclass_t    cls;
    logic [3:0] ex_alu;
    logic       ex_ext;
    logic [3:0] alu_c;
    logic       rdy;
    logic       retire;
    logic       is_r;
    logic       is_bne;

    mc_ctrl_dec u_dec (
        .op     (Op),
        .funct  (Funct),
        .cls    (cls),
        .alu_op (ex_alu),
        .ext_op (ex_ext)
    );

    assign rdy    = (MEM_WAIT != 0) ? mem_rdy : 1'b1;
    assign is_r   = (Op == OP_RTYPE);
    assign is_bne = (Op == OP_BNE);
    assign ALUOp  = ALUOP_W'(alu_c);

    always_comb begin
        nxt    = state;
        retire = 1'b0;
        case (state)
            S_FETCH:  if (rdy) nxt = S_DECODE;
            S_DECODE: begin
                case (cls)
                    C_LOAD, C_STORE: nxt = S_MEMADR;
                    C_BRANCH:        nxt = S_BRANCH;
                    C_JUMP, C_JLINK: nxt = S_JUMP;
                    C_ILLEGAL:       nxt = S_FETCH;
                    default:         nxt = S_EXEC;
                endcase
            end
            S_EXEC:   nxt = S_WB_ALU;
            S_MEMADR: nxt = (cls == C_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (rdy) nxt = S_WB_MEM;
            S_MEMWR: begin
                if (rdy) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            state <= nxt;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        EXTOp    = 1'b0;
        ALUSrcA  = A_PC;
        ALUSrcB  = B_RT;
        alu_c    = ALU_NOP;
        NPCOp    = NPC_PC4;
        GPRSel   = GPR_RD;
        WDSel    = WD_ALU;
        illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = rdy;
                PCWrite = rdy;
                ALUSrcB = B_FOUR;
                alu_c   = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB = B_IMMSH;
                alu_c   = ALU_ADD;
                EXTOp   = 1'b1;
                illegal = (cls == C_ILLEGAL);
            end
            // WB_ALU keeps the EXEC ALU controls so ALUOut stays meaningful
            S_EXEC, S_WB_ALU: begin
                alu_c    = ex_alu;
                EXTOp    = ex_ext;
                ALUSrcA  = (cls == C_SHIFT) ? A_SHAMT : A_RS;
                ALUSrcB  = (cls == C_IMM) ? B_IMM : B_RT;
                RegWrite = (state == S_WB_ALU);
                GPRSel   = is_r ? GPR_RD : GPR_RT;
            end
            S_MEMADR, S_MEMRD, S_MEMWR: begin
                ALUSrcA  = A_RS;
                ALUSrcB  = B_IMM;
                alu_c    = ALU_ADD;
                EXTOp    = 1'b1;
                IorD     = (state != S_MEMADR);
                MemRead  = (state == S_MEMRD);
                MemWrite = (state == S_MEMWR);
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                WDSel    = WD_MEM;
                GPRSel   = GPR_RT;
            end
            S_BRANCH: begin
                ALUSrcA = A_RS;
                alu_c   = ALU_SUB;
                EXTOp   = 1'b1;
                NPCOp   = NPC_BR;
                PCWrite = is_bne ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                NPCOp    = is_r ? NPC_RS : NPC_JMP;
                RegWrite = (cls == C_JLINK);
                WDSel    = WD_PC;
                GPRSel   = is_r ? GPR_RD : GPR_RA;
            end
            default: ;
        endcase
        // Reset overrides every enable asynchronously, even mid-instruction
        if (!rstn) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction vector table plus hand
// sequences for reset, memory wait-states, illegal opcodes and counter wrap.
module tb_mc_ctrl;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [5:0]    Op = 6'h00;
    logic [5:0]    Funct = 6'h00;
    logic          Zero = 1'b0;
    logic          mem_rdy = 1'b1;
    logic          PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp;
    logic [1:0]    ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel;
    logic [AW-1:0] ALUOp;
    logic          illegal;
    logic [CW-1:0] retired;

    mc_ctrl #(.ALUOP_W(AW), .MEM_WAIT(1), .CNT_W(CW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .mem_rdy  (mem_rdy),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .EXTOp    (EXTOp),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .NPCOp    (NPCOp),
        .GPRSel   (GPRSel),
        .WDSel    (WDSel),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_ret = 0;

    // -1 in sa3/ext3 means "not constrained for this instruction"
    typedef struct {
        int op, fn, z, cyc, chk3, alu3, sa3, sb3, ext3;
        int pcw, rw, gpr, wd, cnpc, npc;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int op, int fn, int z, int cyc, int chk3,
                                int alu3, int sa3, int sb3, int ext3,
                                int pcw, int rw, int gpr, int wd,
                                int cnpc, int npc);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.cyc = cyc; v.chk3 = chk3;
        v.alu3 = alu3; v.sa3 = sa3; v.sb3 = sb3; v.ext3 = ext3;
        v.pcw = pcw; v.rw = rw; v.gpr = gpr; v.wd = wd;
        v.cnpc = cnpc; v.npc = npc;
        return v;
    endfunction

    task automatic bump_ret(input string nm);
        exp_ret = (exp_ret + 1) % 16;
        chk(nm, 32'(retired), exp_ret);
    endtask

    // Runs one instruction from FETCH with mem_rdy=1 until retired moves
    task automatic run(input int k, input vec_t v);
        int n = 0;
        int rwc = 0;
        bit done = 0;
        logic [CW-1:0] start;
        logic [31:0] a3 = 0, s3 = 0, b3 = 0, e3 = 0;
        logic [31:0] pcw = 0, gpr = 0, wd = 0, npc = 0;
        Op = 6'(v.op);
        Funct = 6'(v.fn);
        Zero = 1'(v.z);
        mem_rdy = 1'b1;
        start = retired;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                a3 = 32'(ALUOp); s3 = 32'(ALUSrcA);
                b3 = 32'(ALUSrcB); e3 = 32'(EXTOp);
            end
            if (RegWrite) rwc++;
            pcw = 32'(PCWrite); gpr = 32'(GPRSel);
            wd = 32'(WDSel); npc = 32'(NPCOp);
            @(posedge clk);
            #1;
            if (retired != start) done = 1;
        end
        chk($sformatf("v%0d cycles", k), n, v.cyc);
        if (v.chk3 != 0) begin
            chk($sformatf("v%0d ALUOp", k), a3, v.alu3);
            chk($sformatf("v%0d ALUSrcB", k), b3, v.sb3);
            if (v.sa3 >= 0) chk($sformatf("v%0d ALUSrcA", k), s3, v.sa3);
            if (v.ext3 >= 0) chk($sformatf("v%0d EXTOp", k), e3, v.ext3);
        end
        chk($sformatf("v%0d PCWrite", k), pcw, v.pcw);
        chk($sformatf("v%0d RegWrite count", k), rwc, v.rw);
        if (v.rw != 0) begin
            chk($sformatf("v%0d GPRSel", k), gpr, v.gpr);
            chk($sformatf("v%0d WDSel", k), wd, v.wd);
        end
        if (v.cnpc != 0) chk($sformatf("v%0d NPCOp", k), npc, v.npc);
        bump_ret($sformatf("v%0d retired", k));
    endtask

    task automatic lw_wait();
        int n = 0;
        bit done = 0;
        bit held = 1;
        logic [CW-1:0] start;
        logic [31:0] rw = 0, gpr = 0, wd = 0;
        Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
        start = retired;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
            mem_rdy = (n == 4 || n == 5) ? 1'b0 : 1'b1;
            #1;
            if (n >= 4 && n <= 6 && !(MemRead && IorD)) held = 0;
            if (n == 7) begin
                rw = 32'(RegWrite); gpr = 32'(GPRSel); wd = 32'(WDSel);
            end
            @(posedge clk);
            #1;
            if (retired != start) done = 1;
        end
        mem_rdy = 1'b1;
        chk("lw wait cycles", n, 7);
        chk("lw MEMRD held", 32'(held), 1);
        chk("lw WB RegWrite", rw, 1);
        chk("lw WB GPRSel", gpr, 1);
        chk("lw WB WDSel", wd, 1);
        bump_ret("lw wait retired");
    endtask

    task automatic illegal_seq();
        Op = 6'h3f; Funct = 6'h00; mem_rdy = 1'b1;
        @(negedge clk);
        chk("ill fetch pulse", 32'(illegal), 0);
        @(posedge clk);
        #1;
        chk("ill decode pulse", 32'(illegal), 1);
        @(posedge clk);
        #1;
        chk("ill back fetch MemRead", 32'(MemRead), 1);
        chk("ill pulse cleared", 32'(illegal), 0);
        chk("ill retired", 32'(retired), exp_ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vt[0]  = mk(6'h00, 6'h21, 0, 4, 1, 1, 1, 0, -1, 0, 1, 0, 0, 0, 0);
        vt[1]  = mk(6'h00, 6'h22, 0, 4, 1, 2, 1, 0, -1, 0, 1, 0, 0, 0, 0);
        vt[2]  = mk(6'h00, 6'h00, 0, 4, 1, 8, 2, 0, -1, 0, 1, 0, 0, 0, 0);
        vt[3]  = mk(6'h00, 6'h06, 0, 4, 1, 9, 1, 0, -1, 0, 1, 0, 0, 0, 0);
        vt[4]  = mk(6'h00, 6'h27, 0, 4, 1, 10, 1, 0, -1, 0, 1, 0, 0, 0, 0);
        vt[5]  = mk(6'h00, 6'h2b, 0, 4, 1, 6, 1, 0, -1, 0, 1, 0, 0, 0, 0);
        vt[6]  = mk(6'h08, 6'h00, 0, 4, 1, 1, 1, 2, 1, 0, 1, 1, 0, 0, 0);
        vt[7]  = mk(6'h0c, 6'h00, 0, 4, 1, 3, 1, 2, 0, 0, 1, 1, 0, 0, 0);
        vt[8]  = mk(6'h0d, 6'h00, 0, 4, 1, 4, 1, 2, 0, 0, 1, 1, 0, 0, 0);
        vt[9]  = mk(6'h0a, 6'h00, 0, 4, 1, 5, 1, 2, 1, 0, 1, 1, 0, 0, 0);
        vt[10] = mk(6'h0f, 6'h00, 0, 4, 1, 11, -1, 2, -1, 0, 1, 1, 0, 0, 0);
        vt[11] = mk(6'h23, 6'h00, 0, 5, 1, 1, 1, 2, 1, 0, 1, 1, 1, 0, 0);
        vt[12] = mk(6'h2b, 6'h00, 0, 4, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        vt[13] = mk(6'h04, 6'h00, 1, 3, 0, 0, 0, 0, -1, 1, 0, 0, 0, 1, 1);
        vt[14] = mk(6'h04, 6'h00, 0, 3, 0, 0, 0, 0, -1, 0, 0, 0, 0, 1, 1);
        vt[15] = mk(6'h05, 6'h00, 1, 3, 0, 0, 0, 0, -1, 0, 0, 0, 0, 1, 1);
        vt[16] = mk(6'h05, 6'h00, 0, 3, 0, 0, 0, 0, -1, 1, 0, 0, 0, 1, 1);
        vt[17] = mk(6'h02, 6'h00, 0, 3, 0, 0, 0, 0, -1, 1, 0, 0, 0, 1, 2);
        vt[18] = mk(6'h03, 6'h00, 0, 3, 0, 0, 0, 0, -1, 1, 1, 2, 2, 1, 2);
        vt[19] = mk(6'h00, 6'h08, 0, 3, 0, 0, 0, 0, -1, 1, 0, 0, 0, 1, 3);
        vt[20] = mk(6'h00, 6'h09, 0, 3, 0, 0, 0, 0, -1, 1, 1, 0, 2, 1, 3);

        Op = 6'h23;
        repeat (2) @(posedge clk);
        #1;
        chk("rst MemRead", 32'(MemRead), 0);
        chk("rst PCWrite", 32'(PCWrite), 0);
        chk("rst IRWrite", 32'(IRWrite), 0);
        chk("rst retired", 32'(retired), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel MemRead", 32'(MemRead), 1);

        repeat (3) @(posedge clk);
        #1;
        mem_rdy = 1'b0;
        #1;
        chk("memrd MemRead", 32'(MemRead), 1);
        chk("memrd IorD", 32'(IorD), 1);
        @(posedge clk);
        #1;
        chk("memrd wait IorD", 32'(IorD), 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst MemRead", 32'(MemRead), 0);
        chk("midrst RegWrite", 32'(RegWrite), 0);
        chk("midrst retired", 32'(retired), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post rst MemRead", 32'(MemRead), 1);
        chk("post rst IorD", 32'(IorD), 0);
        chk("fetch wait IRWrite", 32'(IRWrite), 0);
        chk("fetch wait PCWrite", 32'(PCWrite), 0);
        Op = 6'h02;
        @(posedge clk);
        #1;
        chk("fetch hold MemRead", 32'(MemRead), 1);
        chk("fetch hold IRWrite", 32'(IRWrite), 0);
        mem_rdy = 1'b1;
        #1;
        chk("fetch rdy IRWrite", 32'(IRWrite), 1);
        chk("fetch rdy PCWrite", 32'(PCWrite), 1);
        repeat (3) @(posedge clk);
        #1;
        bump_ret("first j retired");

        for (int i = 0; i < 21; i++) run(i, vt[i]);

        lw_wait();
        illegal_seq();

        rstn = 1'b0;
        #1;
        chk("rst2 retired", 32'(retired), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_ret = 0;
        for (int i = 0; i < 16; i++) run(100 + i, vt[17]);
        chk("wrap retired", 32'(retired), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
